// File: rtl/uart_cmd_tx.sv
// Byte-oriented UART transmitter: 8N1/8E1/8N2/8E2 framing, LSB first, fed by a small
// first-word-fall-through FIFO. Line, busy and tx_done are registered off the FSM state.
module uart_cmd_tx #(
  parameter int unsigned BAUD_DIV  = 434,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned PARITY_EN = 0,
  parameter int unsigned FIFO_AW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             uart_txd,
  output logic             busy,
  output logic             tx_done,
  output logic [FIFO_AW:0] fifo_level
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned CntW  = $clog2(BAUD_DIV);
  localparam int unsigned LvlW  = FIFO_AW + 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [2:0]         bit_q;
  logic [7:0]         shift_q;
  logic               par_q;
  logic               txd_q;
  logic               done_q;
  logic               busy_q;
  logic               ready_q;
  logic [7:0]         mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [LvlW-1:0]    level_q;
  logic [LvlW-1:0]    level_d;
  logic [7:0]         rd_data;
  logic               push;
  logic               pop;
  logic               baud_tc;
  logic               stop_last;
  logic               txd_d;

  assign rd_data   = mem_q[rd_ptr_q];
  assign push      = tx_valid && ready_q;
  assign baud_tc   = (cnt_q == CntW'(BAUD_DIV - 1));
  assign stop_last = (state_q == StStop) && baud_tc && (bit_q == 3'(STOP_BITS - 1));
  // Pop in IDLE, or in the last STOP cycle so the next start bit follows with no gap.
  assign pop       = (level_q != '0) && ((state_q == StIdle) || stop_last);

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LvlW'(1);
    end
  end

  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shift_q[0];
      StParity: txd_d = par_q;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      end
      level_q <= level_d;
      ready_q <= (level_d != LvlW'(Depth));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      txd_q  <= txd_d;
      done_q <= stop_last;
      busy_q <= (state_q != StIdle) || (level_q != '0);
      if (state_q != StIdle) begin
        cnt_q <= baud_tc ? '0 : cnt_q + CntW'(1);
      end
      case (state_q)
        StIdle: begin
          if (pop) begin
            shift_q <= rd_data;
            par_q   <= ^rd_data;
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (baud_tc) begin
            bit_q   <= '0;
            state_q <= StData;
          end
        end
        StData: begin
          if (baud_tc) begin
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7) begin
              bit_q   <= '0;
              state_q <= (PARITY_EN != 0) ? StParity : StStop;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end
        end
        StParity: begin
          if (baud_tc) begin
            bit_q   <= '0;
            state_q <= StStop;
          end
        end
        StStop: begin
          if (baud_tc) begin
            if (stop_last) begin
              bit_q <= '0;
              if (pop) begin
                shift_q <= rd_data;
                par_q   <= ^rd_data;
                state_q <= StStart;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_ready   = ready_q;
  assign uart_txd   = txd_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;
  assign fifo_level = level_q;

endmodule
